wb_queue: RTL and testbench

//   Write-back side of the operand-forwarding path. Accepts register-file write

---
 rtl/wb_queue.sv | 129 ++++++++++++
 tb/tb_wb_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue: in-order FIFO of pending regfile writes
// with one retire per cycle and a combinational forwarding lookup.
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_we_i,
    input  logic [ADDR_W-1:0]          mem_addr_i,
    input  logic [DATA_W-1:0]          mem_data_i,
    input  logic                       ex_we_i,
    input  logic [ADDR_W-1:0]          ex_addr_i,
    input  logic [DATA_W-1:0]          ex_data_i,
    output logic                       full_o,
    output logic                       reg_we_o,
    output logic [ADDR_W-1:0]          reg_waddr_o,
    output logic [DATA_W-1:0]          reg_wdata_o,
    input  logic [ADDR_W-1:0]          look_addr_i,
    output logic                       look_hit_o,
    output logic [DATA_W-1:0]          look_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic              pop;
    logic              mem_req;
    logic              ex_req;
    logic              mem_acc;
    logic              ex_acc;
    logic              ovf;
    logic [PW-1:0]     ex_slot;
    logic [1:0]        n_push;
    logic [CW-1:0]     count_next;
    int                free;

    // Push admission: free space counts the same-edge pop; EX drops first.
    always_comb begin
        pop        = (count != '0);
        mem_req    = mem_we_i && (mem_addr_i != '0);
        ex_req     = ex_we_i && (ex_addr_i != '0);
        free       = DEPTH - int'(count) + int'(pop);
        mem_acc    = mem_req && (free >= 1);
        ex_acc     = ex_req && (free >= (mem_acc ? 2 : 1));
        ovf        = (mem_req && !mem_acc) || (ex_req && !ex_acc);
        n_push     = 2'(mem_acc) + 2'(ex_acc);
        ex_slot    = mem_acc ? wr_ptr + PW'(1) : wr_ptr;
        count_next = CW'(int'(count) - int'(pop) + int'(n_push));
    end

    // Pointers, occupancy, valid bits, sticky error and retire register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            valid       <= '0;
            err_o       <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else begin
            count  <= count_next;
            wr_ptr <= wr_ptr + PW'(n_push);
            if (ovf)
                err_o <= 1'b1;
            reg_we_o <= pop;
            if (pop) begin
                reg_waddr_o   <= q_addr[rd_ptr];
                reg_wdata_o   <= q_data[rd_ptr];
                rd_ptr        <= rd_ptr + PW'(1);
                valid[rd_ptr] <= 1'b0;
            end
            if (mem_acc)
                valid[wr_ptr] <= 1'b1;
            if (ex_acc)
                valid[ex_slot] <= 1'b1;
        end
    end

    // Entry payload storage; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (mem_acc) begin
            q_addr[wr_ptr] <= mem_addr_i;
            q_data[wr_ptr] <= mem_data_i;
        end
        if (ex_acc) begin
            q_addr[ex_slot] <= ex_addr_i;
            q_data[ex_slot] <= ex_data_i;
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx         = '0;
        look_hit_o  = 1'b0;
        look_data_o = '0;
        if (reg_we_o && (reg_waddr_o == look_addr_i)) begin
            look_hit_o  = 1'b1;
            look_data_o = reg_wdata_o;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (valid[idx] && (q_addr[idx] == look_addr_i)) begin
                look_hit_o  = 1'b1;
                look_data_o = q_data[idx];
            end
        end
        if (look_addr_i == '0) begin
            look_hit_o  = 1'b0;
            look_data_o = '0;
        end
    end

    assign count_o = count;
    assign full_o  = (count > CW'(DEPTH - 2));

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_wb_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we_i = 1'b0;
    logic [4:0]  mem_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        ex_we_i = 1'b0;
    logic [4:0]  ex_addr_i = '0;
    logic [31:0] ex_data_i = '0;
    logic        full_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic [4:0]  look_addr_i = '0;
    logic        look_hit_o;
    logic [31:0] look_data_o;
    logic [2:0]  count_o;
    logic        err_o;

    wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i),
        .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i),
        .ex_data_i(ex_data_i),
        .full_o(full_o), .reg_we_o(reg_we_o),
        .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .look_addr_i(look_addr_i), .look_hit_o(look_hit_o),
        .look_data_o(look_data_o), .count_o(count_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_err;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_look(input logic [4:0] a,
                              output logic hit,
                              output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 0) begin
            if (m_we && m_addr == a) begin
                hit = 1'b1;
                d   = m_data;
            end
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].addr == a) begin
                    hit = 1'b1;
                    d   = q[i].data;
                end
            end
        end
    endtask

    task automatic check_state();
        logic        h;
        logic [31:0] d;
        model_look(look_addr_i, h, d);
        chk("count", 64'(count_o), 64'(q.size()));
        chk("full", 64'(full_o), 64'(q.size() > DEPTH - 2));
        chk("err", 64'(err_o), 64'(m_err));
        chk("reg_we", 64'(reg_we_o), 64'(m_we));
        chk("reg_waddr", 64'(reg_waddr_o), 64'(m_addr));
        chk("reg_wdata", 64'(reg_wdata_o), 64'(m_data));
        chk("look_hit", 64'(look_hit_o), 64'(h));
        chk("look_data", 64'(look_data_o), 64'(d));
    endtask

    task automatic step(input logic mw, input logic [4:0] ma,
                        input logic [31:0] md,
                        input logic ew, input logic [4:0] ea,
                        input logic [31:0] ed,
                        input logic [4:0] la);
        ent_t e;
        mem_we_i    = mw;
        mem_addr_i  = ma;
        mem_data_i  = md;
        ex_we_i     = ew;
        ex_addr_i   = ea;
        ex_data_i   = ed;
        look_addr_i = la;
        #1;
        check_state();
        @(posedge clk);
        if (q.size() > 0) begin
            e      = q.pop_front();
            m_we   = 1'b1;
            m_addr = e.addr;
            m_data = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (mw && ma != 0) begin
            if (q.size() < DEPTH) q.push_back('{ma, md});
            else m_err = 1'b1;
        end
        if (ew && ea != 0) begin
            if (q.size() < DEPTH) q.push_back('{ea, ed});
            else m_err = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] la);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, la);
    endtask

    task automatic do_reset();
        mem_we_i = 1'b0;
        ex_we_i  = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_we", 64'(reg_we_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        step(1, 1, 32'h101, 1, 2, 32'h102, 0);
        step(1, 4, 32'h104, 1, 6, 32'h106, 1);
        chk("pre_rst_count", 64'(count_o), 64'd3);
        do_reset();
        idle(3, 1);

        step(1, 5, 32'hA5, 0, 0, 0, 5);
        step(0, 0, 0, 0, 0, 0, 5);
        chk("single_waddr", 64'(reg_waddr_o), 64'd5);
        chk("single_wdata", 64'(reg_wdata_o), 64'hA5);

        step(1, 3, 32'h11, 1, 3, 32'h22, 3);
        mem_we_i    = 1'b0;
        ex_we_i     = 1'b0;
        look_addr_i = 5'd3;
        #1;
        chk("dual_fwd", 64'(look_data_o), 64'h22);
        step(0, 0, 0, 0, 0, 0, 3);
        chk("dual_ret0", 64'(reg_wdata_o), 64'h11);
        step(0, 0, 0, 0, 0, 0, 3);
        chk("dual_ret1", 64'(reg_wdata_o), 64'h22);
        idle(1, 3);

        step(0, 0, 0, 1, 0, 32'hFF, 0);
        idle(2, 0);

        for (int i = 0; i < 4; i++)
            step(1, 5'(8 + 2 * i), 32'h200 + i,
                 1, 5'(9 + 2 * i), 32'h300 + i, 5'(9 + 2 * i));
        chk("ovf_err", 64'(err_o), 64'd1);
        idle(6, 14);
        do_reset();

        for (int i = 1; i <= 10; i++)
            step(1, 5'(i), 32'h400 + i, 0, 0, 0, 5'(i));
        idle(3, 10);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                     $urandom,
                     $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                     $urandom,
                     5'($urandom_range(0, 7)));
            end
        end
        idle(4, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
